// File: rtl/fb_pattern_writer.sv
// Framebuffer stimulus engine: walks a single pixel on a timer, or sweeps a
// full frame with fill / clear / checkerboard data over a valid/ready port.
module fb_pattern_writer #(
  parameter int unsigned       WIDTH     = 128,
  parameter int unsigned       HEIGHT    = 64,
  parameter int unsigned       COORD_W   = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       TICK_DIV  = 27000000,
  parameter logic [DATA_W-1:0] WALK_DATA = DATA_W'(8'h01)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  if ((WIDTH > 2**COORD_W) || (HEIGHT > 2**COORD_W) || (TICK_DIV < 2)) begin : g_param_check
    $error("fb_pattern_writer: WIDTH/HEIGHT exceed COORD_W range or TICK_DIV < 2");
  end

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_WALK    = 2'd0,
    M_FILL    = 2'd1,
    M_CLEAR   = 2'd2,
    M_CHECKER = 2'd3
  } mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic                accept;
  logic                x_wrap, frame_end;
  logic [COORD_W-1:0]  x_nxt, y_nxt;

  function automatic logic [DATA_W-1:0] pattern(input mode_t m,
                                                input logic [COORD_W-1:0] px,
                                                input logic [COORD_W-1:0] py);
    logic [DATA_W-1:0] d;
    case (m)
      M_WALK:    d = WALK_DATA;
      M_FILL:    d = '1;
      M_CLEAR:   d = '0;
      M_CHECKER: d = ((px[0] ^ py[0]) == 1'b0) ? DATA_W'(8'h55) : DATA_W'(8'hAA);
      default:   d = '0;
    endcase
    return d;
  endfunction

  assign accept    = (state_q == S_WRITE) && wr_ready;
  assign x_wrap    = (x_q == X_LAST);
  assign frame_end = x_wrap && (y_q == Y_LAST);
  assign x_nxt     = x_wrap ? '0 : x_q + COORD_W'(1);
  assign y_nxt     = x_wrap ? ((y_q == Y_LAST) ? '0 : y_q + COORD_W'(1)) : y_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    x_d           = x_q;
    y_d           = y_q;
    data_d        = data_q;
    tick_d        = tick_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d  = mode_t'(mode);
          x_d     = '0;
          y_d     = '0;
          tick_d  = '0;
          data_d  = pattern(mode_t'(mode), '0, '0);
          state_d = (mode_t'(mode) == M_WALK) ? S_WAIT_TICK : S_WRITE;
        end
      end

      S_WAIT_TICK: begin
        if (stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = S_WRITE;
        end else begin
          tick_d  = tick_q + TICK_W'(1);
        end
      end

      S_WRITE: begin
        if (accept) begin
          x_d    = x_nxt;
          y_d    = y_nxt;
          data_d = pattern(mode_q, x_nxt, y_nxt);
          if (frame_end) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
        if (stop) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (mode_q == M_WALK) begin
            // The accept cycle itself counts as tick 0, so writes stay TICK_DIV apart.
            state_d = S_WAIT_TICK;
            tick_d  = TICK_W'(1);
          end else if (frame_end) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= M_WALK;
      x_q           <= '0;
      y_q           <= '0;
      data_q        <= '0;
      tick_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      x_q           <= x_d;
      y_q           <= y_d;
      data_q        <= data_d;
      tick_q        <= tick_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wr_valid    = (state_q == S_WRITE);
  assign busy        = (state_q != S_IDLE);
  assign wr_x        = x_q;
  assign wr_y        = y_q;
  assign wr_data     = data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a 4x2 frame with a 3-cycle walk tick.
module tb_fb_pattern_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wr_ready = 1'b1;
  logic        wr_valid;
  logic [7:0]  wr_x, wr_y, wr_data;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  fb_pattern_writer #(
    .WIDTH    (4),
    .HEIGHT   (2),
    .COORD_W  (8),
    .DATA_W   (8),
    .TICK_DIV (3),
    .WALK_DATA(8'h01)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  // Expected write sequence over one frame, with data per sweep mode.
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] d_fill;
    logic [7:0] d_clear;
    logic [7:0] d_chk;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_data(input int m, input int k);
    case (m)
      1:       return int'(tab[k].d_fill);
      2:       return int'(tab[k].d_clear);
      default: return int'(tab[k].d_chk);
    endcase
  endfunction

  // Runs a full non-walk frame; rdy is the repeating wr_ready pattern and
  // inj >= 0 pulses start with mode 3 on that cycle while busy.
  task automatic run_frame(input int m, input logic [3:0] rdy, input int inj);
    int k;
    int cyc;
    logic r;
    @(negedge clk);
    mode = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      chk("frame_valid", int'(wr_valid), 1);
      chk("frame_busy", int'(busy), 1);
      chk("frame_x", int'(wr_x), int'(tab[k].x));
      chk("frame_y", int'(wr_y), int'(tab[k].y));
      chk("frame_data", int'(wr_data), exp_data(m, k));
      chk("frame_done_early", int'(frame_done), 0);
      r = rdy[cyc % 4];
      wr_ready = r;
      if (cyc == inj) begin
        start = 1'b1;
        mode = 2'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    chk("frame_accepts", k, 8);
    chk("frame_done_pulse", int'(frame_done), 1);
    chk("frame_count", int'(frame_count), exp_fc + 1);
    chk("done_valid", int'(wr_valid), 0);
    chk("done_busy", int'(busy), 1);
    exp_fc++;
    @(negedge clk);
    chk("frame_done_clear", int'(frame_done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(wr_valid), 0);
  endtask

  initial begin
    tab[0] = '{8'd0, 8'd0, 8'hFF, 8'h00, 8'h55};
    tab[1] = '{8'd1, 8'd0, 8'hFF, 8'h00, 8'hAA};
    tab[2] = '{8'd2, 8'd0, 8'hFF, 8'h00, 8'h55};
    tab[3] = '{8'd3, 8'd0, 8'hFF, 8'h00, 8'hAA};
    tab[4] = '{8'd0, 8'd1, 8'hFF, 8'h00, 8'hAA};
    tab[5] = '{8'd1, 8'd1, 8'hFF, 8'h00, 8'h55};
    tab[6] = '{8'd2, 8'd1, 8'hFF, 8'h00, 8'hAA};
    tab[7] = '{8'd3, 8'd1, 8'hFF, 8'h00, 8'h55};

    // Reset state
    #12;
    chk("rst_valid", int'(wr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(wr_x), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_fc", int'(frame_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", int'(busy), 0);

    run_frame(1, 4'b1111, -1);
    run_frame(3, 4'b1001, -1);
    run_frame(2, 4'b1011, -1);

    // Walk mode: writes every 3 cycles, wraps and keeps going
    begin
      int w;
      @(negedge clk);
      wr_ready = 1'b1;
      mode = 2'd0;
      start = 1'b1;
      for (int n = 0; n <= 16; n++) begin
        w = 0;
        do begin
          @(negedge clk);
          start = 1'b0;
          w++;
          if (n > 0 && w == 1) begin
            chk("walk_frame_done", int'(frame_done), ((n - 1) % 8 == 7) ? 1 : 0);
            chk("walk_fc", int'(frame_count), exp_fc + n / 8);
          end
        end while (!wr_valid && w < 20);
        chk("walk_gap", w, (n == 0) ? 4 : 3);
        chk("walk_x", int'(wr_x), n % 4);
        chk("walk_y", int'(wr_y), (n / 4) % 2);
        chk("walk_data", int'(wr_data), 8'h01);
      end
      @(negedge clk);
      chk("walk_busy", int'(busy), 1);
      chk("walk_post_valid", int'(wr_valid), 0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("walk_stop_busy", int'(busy), 0);
      exp_fc += 2;
      chk("walk_stop_fc", int'(frame_count), exp_fc);
    end

    // Stop coinciding with the accept of (2,0) in clear mode
    @(negedge clk);
    mode = 2'd2;
    start = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stop_x0", int'(wr_x), 0);
    @(negedge clk);
    chk("stop_x1", int'(wr_x), 1);
    @(negedge clk);
    chk("stop_x2", int'(wr_x), 2);
    chk("stop_valid_before", int'(wr_valid), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", int'(wr_valid), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_no_done", int'(frame_done), 0);
    chk("stop_counted_x", int'(wr_x), 3);
    chk("stop_fc", int'(frame_count), exp_fc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", int'(wr_valid), 1);
    chk("restart_x", int'(wr_x), 0);
    chk("restart_y", int'(wr_y), 0);
    chk("restart_data", int'(wr_data), 0);

    // Async reset while a write is stalled
    wr_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", int'(wr_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(wr_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_x", int'(wr_x), 0);
    chk("arst_y", int'(wr_y), 0);
    chk("arst_data", int'(wr_data), 0);
    chk("arst_fc", int'(frame_count), 0);
    exp_fc = 0;
    wr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", int'(busy), 0);
      chk("post_rst_valid", int'(wr_valid), 0);
    end

    // Start with a different mode while busy must be ignored
    run_frame(1, 4'b1111, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

endmodule
